// File: rtl/display_arbiter_if.sv
// Request/display bus between requesters and the display arbiter.
interface display_arbiter_if;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         freeze;
  logic [31:0]  LedData;
  logic [1:0]   owner;
  logic         valid;
  logic [3:0]   ack;

  // Requester side: drives requests, observes the grant results
  modport master (
    output req, req_data, freeze,
    input  LedData, owner, valid, ack
  );

  // Arbiter side
  modport slave (
    input  req, req_data, freeze,
    output LedData, owner, valid, ack
  );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter that hands an 8-digit display to one of four
// requesters for at least HOLD cycles, with a freeze input that pauses
// ownership changes while still letting the owner refresh its word.
module display_arbiter #(
  parameter int HOLD = 1000
) (
  input logic              CLK,
  input logic              RST,
  display_arbiter_if.slave bus
);

  localparam int TW = $clog2(HOLD) + 1;
  localparam logic [TW-1:0] HOLD_M1 = TW'(HOLD - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic [1:0]    owner_reg;
  logic [31:0]   led_data_reg;
  logic          valid_reg;
  logic [3:0]    ack_reg;

  logic [1:0]    winner;
  logic [1:0]    cand;
  logic          found;
  logic [31:0]   winner_slot;
  logic [31:0]   owner_slot;
  logic          arb_ok;

  // Round-robin search starting just after the current owner, wrapping
  always_comb begin
    winner = owner_reg;
    found  = 1'b0;
    cand   = owner_reg;
    for (int k = 1; k <= 4; k++) begin
      cand = owner_reg + k[1:0];
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Word selection for the winner and for the refresh of the current owner
  always_comb begin
    winner_slot = bus.req_data[32*winner +: 32];
    owner_slot  = bus.req_data[32*owner_reg +: 32];
    // Arbitration is allowed in IDLE, or in SHOW once the hold has run out
    arb_ok = !bus.freeze && (bus.req != 4'b0000) &&
             ((state_reg == IDLE) || (timer_reg == '0));
  end

  // Ownership FSM, hold timer and registered display outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      owner_reg    <= 2'd3;
      led_data_reg <= 32'h0;
      valid_reg    <= 1'b0;
      ack_reg      <= 4'b0000;
    end else begin
      ack_reg <= 4'b0000;
      if (arb_ok) begin
        state_reg    <= SHOW;
        owner_reg    <= winner;
        led_data_reg <= winner_slot;
        ack_reg      <= 4'b0001 << winner;
        valid_reg    <= 1'b1;
        timer_reg    <= HOLD_M1;
      end else if (state_reg == SHOW) begin
        // Freeze pauses the countdown but not the owner's word refresh
        if (!bus.freeze && timer_reg != '0)
          timer_reg <= timer_reg - 1'b1;
        if (bus.req[owner_reg])
          led_data_reg <= owner_slot;
      end
    end
  end

  assign bus.LedData = led_data_reg;
  assign bus.owner   = owner_reg;
  assign bus.valid   = valid_reg;
  assign bus.ack     = ack_reg;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: one HOLD=4 and one HOLD=1 instance
// share the stimulus; a behavioural model checks both every cycle, and
// hand-computed literals pin the key scenarios.
module tb_display_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'b0000;
  logic [127:0] data = '0;
  logic         freeze = 1'b0;
  bit           checking = 1'b0;
  int           errors = 0;
  int           checks = 0;

  display_arbiter_if bus4();
  display_arbiter_if bus1();

  assign bus4.req = req;  assign bus4.req_data = data;  assign bus4.freeze = freeze;
  assign bus1.req = req;  assign bus1.req_data = data;  assign bus1.freeze = freeze;

  display_arbiter #(.HOLD(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4));
  display_arbiter #(.HOLD(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Model: who owns the display, what it shows, and cycles left before re-arbitration
  typedef struct {
    bit          showing;
    int          owner;
    logic [31:0] led;
    bit          valid;
    logic [3:0]  ack;
    int          left;
  } mstate_t;

  mstate_t m4 = '{showing: 0, owner: 3, led: 0, valid: 0, ack: 0, left: 0};
  mstate_t m1 = '{showing: 0, owner: 3, led: 0, valid: 0, ack: 0, left: 0};

  function automatic mstate_t step(mstate_t s, int hold, logic r, logic f,
                                   logic [3:0] q, logic [127:0] d);
    mstate_t n;
    int w;
    n = s;
    n.ack = 4'b0000;
    w = -1;
    if (r) begin
      n = '{showing: 0, owner: 3, led: 0, valid: 0, ack: 0, left: 0};
      return n;
    end
    if (!f && q != 4'b0000 && (!s.showing || s.left == 0)) begin
      for (int k = 1; k <= 4; k++)
        if (w < 0 && q[(s.owner + k) % 4]) w = (s.owner + k) % 4;
      n.showing = 1;
      n.owner   = w;
      n.led     = d[32*w +: 32];
      n.ack     = 4'(1 << w);
      n.valid   = 1;
      n.left    = hold - 1;
    end else if (s.showing) begin
      if (!f && s.left > 0) n.left = s.left - 1;
      if (q[s.owner]) n.led = d[32*s.owner +: 32];
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [31:0] v);
    data[32*i +: 32] = v;
  endtask

  task automatic expect4(input string tag, input int own, input logic [3:0] ak,
                         input logic [31:0] led, input bit vld);
    chk({tag, ".owner"}, 32'(bus4.owner), 32'(own));
    chk({tag, ".ack"},   32'(bus4.ack),   32'(ak));
    chk({tag, ".led"},   bus4.LedData,    led);
    chk({tag, ".valid"}, 32'(bus4.valid), 32'(vld));
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; freeze = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Model advances on every rising edge with the inputs the DUTs sample
  always @(posedge clk) begin
    m4 = step(m4, 4, rst, freeze, req, data);
    m1 = step(m1, 1, rst, freeze, req, data);
  end

  // Compare both DUTs against the model one step after each edge
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("m4.owner", 32'(bus4.owner), 32'(m4.owner));
      chk("m4.led",   bus4.LedData,    m4.led);
      chk("m4.valid", 32'(bus4.valid), 32'(m4.valid));
      chk("m4.ack",   32'(bus4.ack),   32'(m4.ack));
      chk("m1.owner", 32'(bus1.owner), 32'(m1.owner));
      chk("m1.led",   bus1.LedData,    m1.led);
      chk("m1.valid", 32'(bus1.valid), 32'(m1.valid));
      chk("m1.ack",   32'(bus1.ack),   32'(m1.ack));
      if (bus4.ack != 4'b0000)
        $display("t=%0t hold4 grant owner=%0d ack=%b led=%h", $time, bus4.owner, bus4.ack, bus4.LedData);
      if (bus1.ack != 4'b0000)
        $display("t=%0t hold1 grant owner=%0d ack=%b led=%h", $time, bus1.owner, bus1.ack, bus1.LedData);
    end
  end

  initial begin
    // Reset state and first grant
    do_reset();
    checking = 1'b1;
    expect4("reset", 3, 4'b0000, 32'h0, 1'b0);
    req = 4'b0100; set_slot(2, 32'h1234ABCD);
    tick();
    expect4("first", 2, 4'b0100, 32'h1234ABCD, 1'b1);
    req = 4'b0000;
    tick();
    chk("first.ack_drop", 32'(bus4.ack), 32'h0);

    // All four requesting: owners 0,1,2,3,0, one grant every 4 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 32'(i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      expect4("rr.grant", g % 4, 4'(1 << (g % 4)), 32'(g % 4), 1'b1);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("rr.hold_owner", 32'(bus4.owner), 32'(g % 4));
        chk("rr.hold_ack",   32'(bus4.ack),   32'h0);
      end
    end

    // Owner drops its request: word holds, later requester gets it at once
    do_reset();
    req = 4'b0010; set_slot(1, 32'hAAAA0001);
    tick();
    expect4("drop.grant", 1, 4'b0010, 32'hAAAA0001, 1'b1);
    set_slot(1, 32'hAAAA0002);
    tick();
    chk("drop.refresh", bus4.LedData, 32'hAAAA0002);
    req = 4'b0000; set_slot(1, 32'hBBBB0000);
    for (int c = 0; c < 6; c++) begin
      tick();
      expect4("drop.hold", 1, 4'b0000, 32'hAAAA0002, 1'b1);
    end
    req = 4'b0001; set_slot(0, 32'h0C0C0C0C);
    tick();
    expect4("drop.regrant", 0, 4'b0001, 32'h0C0C0C0C, 1'b1);

    // Freeze right after the grant to 0: owner sticks, word still refreshes
    do_reset();
    req = 4'b0011; set_slot(0, 32'hC0); set_slot(1, 32'hC1);
    tick();
    expect4("frz.grant", 0, 4'b0001, 32'hC0, 1'b1);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_slot(0, 32'hD0000000 + 32'(i));
      tick();
      expect4("frz.held", 0, 4'b0000, 32'hD0000000 + 32'(i), 1'b1);
    end
    freeze = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("frz.count_owner", 32'(bus4.owner), 32'd0);
      chk("frz.count_ack",   32'(bus4.ack),   32'h0);
    end
    tick();
    expect4("frz.next", 1, 4'b0010, 32'hC1, 1'b1);

    // Reset in mid-hold beats freeze and requests
    do_reset();
    req = 4'b1000; set_slot(3, 32'hE3E3E3E3);
    tick();
    expect4("rst.grant", 3, 4'b1000, 32'hE3E3E3E3, 1'b1);
    tick();
    rst = 1'b1; freeze = 1'b1;
    tick();
    expect4("rst.mid", 3, 4'b0000, 32'h0, 1'b0);
    rst = 1'b0; freeze = 1'b0;
    tick();
    expect4("rst.after", 3, 4'b1000, 32'hE3E3E3E3, 1'b1);

    // HOLD=1: contending requesters alternate every cycle
    do_reset();
    req = 4'b0101; set_slot(0, 32'hF0); set_slot(2, 32'hF2);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("h1.owner", 32'(bus1.owner), (c % 2 == 0) ? 32'd0 : 32'd2);
      chk("h1.ack",   32'(bus1.ack),   (c % 2 == 0) ? 32'h1 : 32'h4);
      chk("h1.led",   bus1.LedData,    (c % 2 == 0) ? 32'hF0 : 32'hF2);
    end

    checking = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
